cdb_arbiter: RTL and testbench

- Collects completed results from the ALU, MUL and LSU functional units and broadcasts one result per cycle on the common data bus (CDB).
- The CDB tag/enable drive the wake-up inputs of the reservation station and the register-file write port.
- Each unit gets a small completion FIFO, so a losing unit can keep retiring without stalling until its FIFO fills.
- A round-robin arbiter prevents starvation.

---
 rtl/cdb_arbiter.sv | 155 +++++++++++++++
 tb/tb_cdb_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: three per-unit completion FIFOs feeding a round-robin
// arbiter that broadcasts one {tag, data} result per cycle on registered CDB outputs.
module cdb_arbiter #(
    parameter int FIFO_DEPTH = 2,
    parameter int TAG_W      = 5,
    parameter int DATA_W     = 32
) (
    input  logic              clk_i,
    input  logic              reset_ni,
    input  logic              alu_valid_i,
    input  logic [TAG_W-1:0]  alu_tag_i,
    input  logic [DATA_W-1:0] alu_data_i,
    output logic              alu_ready_o,
    input  logic              mul_valid_i,
    input  logic [TAG_W-1:0]  mul_tag_i,
    input  logic [DATA_W-1:0] mul_data_i,
    output logic              mul_ready_o,
    input  logic              lsu_valid_i,
    input  logic [TAG_W-1:0]  lsu_tag_i,
    input  logic [DATA_W-1:0] lsu_data_i,
    output logic              lsu_ready_o,
    output logic              cdb_en_o,
    output logic [TAG_W-1:0]  cdb_tag_o,
    output logic [DATA_W-1:0] cdb_data_o,
    output logic [1:0]        cdb_src_o
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int ENT_W = TAG_W + DATA_W;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    logic [ENT_W-1:0]  mem_q [3][FIFO_DEPTH];
    logic [PTR_W-1:0]  wptr_q [3];
    logic [PTR_W-1:0]  wptr_d [3];
    logic [PTR_W-1:0]  rptr_q [3];
    logic [PTR_W-1:0]  rptr_d [3];
    logic [CNT_W-1:0]  count_q [3];
    logic [CNT_W-1:0]  count_d [3];
    logic              in_valid [3];
    logic [ENT_W-1:0]  in_entry [3];
    logic              ready [3];
    logic              push [3];
    logic              pop [3];

    logic [1:0]        last_grant_q, last_grant_d;
    logic [1:0]        win;
    logic [2:0]        cand;
    logic              grant;
    logic [ENT_W-1:0]  head;

    logic              cdb_en_q, cdb_en_d;
    logic [TAG_W-1:0]  cdb_tag_q, cdb_tag_d;
    logic [DATA_W-1:0] cdb_data_q, cdb_data_d;
    logic [1:0]        cdb_src_q, cdb_src_d;

    always_comb begin
        in_valid[0] = alu_valid_i;
        in_valid[1] = mul_valid_i;
        in_valid[2] = lsu_valid_i;
        in_entry[0] = {alu_tag_i, alu_data_i};
        in_entry[1] = {mul_tag_i, mul_data_i};
        in_entry[2] = {lsu_tag_i, lsu_data_i};
    end

    // Ready looks only at the registered count, so a same-cycle pop never frees a slot early.
    always_comb begin
        for (int s = 0; s < 3; s++) begin
            ready[s] = (count_q[s] != CNT_FULL);
            push[s]  = in_valid[s] && ready[s];
        end
    end

    // Round-robin search beginning one past the previous winner, wrapping ALU -> MUL -> LSU.
    always_comb begin
        grant = 1'b0;
        win   = 2'd0;
        cand  = 3'd0;
        for (int k = 1; k <= 3; k++) begin
            cand = {1'b0, last_grant_q} + 3'(k);
            if (cand >= 3'd3) begin
                cand = cand - 3'd3;
            end
            if (!grant && (count_q[cand[1:0]] != '0)) begin
                grant = 1'b1;
                win   = cand[1:0];
            end
        end
    end

    always_comb begin
        head         = mem_q[win][rptr_q[win]];
        last_grant_d = grant ? win : last_grant_q;
        cdb_en_d     = grant;
        cdb_tag_d    = grant ? head[ENT_W-1:DATA_W] : cdb_tag_q;
        cdb_data_d   = grant ? head[DATA_W-1:0]     : cdb_data_q;
        cdb_src_d    = grant ? win                  : cdb_src_q;
        for (int s = 0; s < 3; s++) begin
            pop[s]    = grant && (win == 2'(s));
            wptr_d[s] = push[s] ? wptr_q[s] + PTR_ONE : wptr_q[s];
            rptr_d[s] = pop[s]  ? rptr_q[s] + PTR_ONE : rptr_q[s];
            case ({push[s], pop[s]})
                2'b10:   count_d[s] = count_q[s] + CNT_ONE;
                2'b01:   count_d[s] = count_q[s] - CNT_ONE;
                default: count_d[s] = count_q[s];
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            for (int s = 0; s < 3; s++) begin
                wptr_q[s]  <= '0;
                rptr_q[s]  <= '0;
                count_q[s] <= '0;
            end
            last_grant_q <= 2'd2;
            cdb_en_q     <= 1'b0;
            cdb_tag_q    <= '0;
            cdb_data_q   <= '0;
            cdb_src_q    <= 2'd0;
        end else begin
            for (int s = 0; s < 3; s++) begin
                wptr_q[s]  <= wptr_d[s];
                rptr_q[s]  <= rptr_d[s];
                count_q[s] <= count_d[s];
            end
            last_grant_q <= last_grant_d;
            cdb_en_q     <= cdb_en_d;
            cdb_tag_q    <= cdb_tag_d;
            cdb_data_q   <= cdb_data_d;
            cdb_src_q    <= cdb_src_d;
        end
    end

    // Storage needs no reset: the counts alone decide which slots hold live entries.
    always_ff @(posedge clk_i) begin
        for (int s = 0; s < 3; s++) begin
            if (push[s]) begin
                mem_q[s][wptr_q[s]] <= in_entry[s];
            end
        end
    end

    assign alu_ready_o = ready[0];
    assign mul_ready_o = ready[1];
    assign lsu_ready_o = ready[2];
    assign cdb_en_o    = cdb_en_q;
    assign cdb_tag_o   = cdb_tag_q;
    assign cdb_data_o  = cdb_data_q;
    assign cdb_src_o   = cdb_src_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Randomized scoreboard bench for cdb_arbiter: a queue-based reference model predicts
// every broadcast and ready value; a negedge monitor pops and compares.
module tb_cdb_arbiter;

    localparam int DEPTH = 2;
    localparam int TW    = 5;
    localparam int DW    = 32;

    typedef struct packed {
        logic [TW-1:0] tag;
        logic [DW-1:0] data;
    } item_t;

    typedef struct packed {
        logic [1:0]    src;
        logic [TW-1:0] tag;
        logic [DW-1:0] data;
    } bcast_t;

    logic          clk_i;
    logic          reset_ni;
    logic          vld [3];
    logic [TW-1:0] tagIn [3];
    logic [DW-1:0] dataIn [3];
    logic          rdy [3];
    logic          cdb_en_o;
    logic [TW-1:0] cdb_tag_o;
    logic [DW-1:0] cdb_data_o;
    logic [1:0]    cdb_src_o;

    item_t         mq [3][$];
    item_t         srcQ [3][$];
    bcast_t        sbq [$];
    int            srcLog [$];
    logic [TW-1:0] tagLog [$];
    int            lastGrant;
    bit            expEn;
    bit            acc [3];
    int            gapPct;
    int            checks;
    int            errors;
    int            mWin;
    int            mCand;
    item_t         mIt;
    bcast_t        mB;
    bcast_t        monB;

    cdb_arbiter #(.FIFO_DEPTH(DEPTH), .TAG_W(TW), .DATA_W(DW)) dut (
        .clk_i       (clk_i),
        .reset_ni    (reset_ni),
        .alu_valid_i (vld[0]),
        .alu_tag_i   (tagIn[0]),
        .alu_data_i  (dataIn[0]),
        .alu_ready_o (rdy[0]),
        .mul_valid_i (vld[1]),
        .mul_tag_i   (tagIn[1]),
        .mul_data_i  (dataIn[1]),
        .mul_ready_o (rdy[1]),
        .lsu_valid_i (vld[2]),
        .lsu_tag_i   (tagIn[2]),
        .lsu_data_i  (dataIn[2]),
        .lsu_ready_o (rdy[2]),
        .cdb_en_o    (cdb_en_o),
        .cdb_tag_o   (cdb_tag_o),
        .cdb_data_o  (cdb_data_o),
        .cdb_src_o   (cdb_src_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic item_t mkItem(input logic [TW-1:0] t, input logic [DW-1:0] d);
        item_t it;
        it.tag  = t;
        it.data = d;
        return it;
    endfunction

    function automatic bit idle();
        bit r;
        r = (sbq.size() == 0);
        for (int s = 0; s < 3; s++) begin
            if (srcQ[s].size() != 0 || vld[s] || mq[s].size() != 0) r = 1'b0;
        end
        return r;
    endfunction

    function automatic void clearModel();
        for (int s = 0; s < 3; s++) begin
            mq[s].delete();
            acc[s] = 1'b0;
        end
        sbq.delete();
        lastGrant = 2;
        expEn     = 1'b0;
    endfunction

    // Reference model: queues per unit, winner is the first nonempty unit after the last winner.
    always @(posedge clk_i) begin
        if (reset_ni) begin
            for (int s = 0; s < 3; s++) acc[s] = vld[s] && (mq[s].size() < DEPTH);
            mWin = -1;
            for (int k = 1; k <= 3; k++) begin
                mCand = (lastGrant + k) % 3;
                if (mWin < 0 && mq[mCand].size() > 0) mWin = mCand;
            end
            if (mWin >= 0) begin
                mIt    = mq[mWin].pop_front();
                mB.src  = 2'(mWin);
                mB.tag  = mIt.tag;
                mB.data = mIt.data;
                sbq.push_back(mB);
                lastGrant = mWin;
                expEn     = 1'b1;
            end else begin
                expEn = 1'b0;
            end
            for (int s = 0; s < 3; s++) begin
                if (acc[s]) mq[s].push_back(mkItem(tagIn[s], dataIn[s]));
            end
        end
    end

    always @(negedge clk_i) begin
        if (reset_ni) begin
            for (int s = 0; s < 3; s++) begin
                checkOutput($sformatf("ready%0d", s), {63'd0, rdy[s]}, {63'd0, (mq[s].size() < DEPTH)});
            end
            checkOutput("cdb_en", {63'd0, cdb_en_o}, {63'd0, expEn});
            if (cdb_en_o) begin
                srcLog.push_back(int'(cdb_src_o));
                tagLog.push_back(cdb_tag_o);
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL cdb_unexpected: got broadcast tag %0h, expected none", cdb_tag_o);
                end else begin
                    monB = sbq.pop_front();
                    checkOutput("cdb_src", 64'(cdb_src_o), 64'(monB.src));
                    checkOutput("cdb_tag", 64'(cdb_tag_o), 64'(monB.tag));
                    checkOutput("cdb_data", 64'(cdb_data_o), 64'(monB.data));
                end
            end
        end
    end

    // Producers hold a completion on the bus until the model says it was accepted.
    task automatic stepCycle();
        @(posedge clk_i);
        #1;
        for (int s = 0; s < 3; s++) begin
            if (vld[s] && acc[s]) begin
                void'(srcQ[s].pop_front());
                vld[s] = 1'b0;
            end
            if (!vld[s] && srcQ[s].size() > 0 && $urandom_range(99) >= 32'(gapPct)) begin
                vld[s]    = 1'b1;
                tagIn[s]  = srcQ[s][0].tag;
                dataIn[s] = srcQ[s][0].data;
            end
        end
    endtask

    task automatic applyStimulus(input int gap);
        bit done;
        gapPct = gap;
        done   = 1'b0;
        for (int n = 0; n < 3000 && !done; n++) begin
            stepCycle();
            done = idle();
        end
        checks++;
        if (!done) begin
            errors++;
            $display("[TB] FAIL drain_timeout: got pending traffic, expected idle within 3000 cycles");
        end
        @(negedge clk_i);
    endtask

    task automatic doReset();
        @(negedge clk_i);
        reset_ni = 1'b0;
        clearModel();
        for (int s = 0; s < 3; s++) begin
            srcQ[s].delete();
            vld[s] = 1'b0;
        end
        repeat (2) @(negedge clk_i);
        reset_ni = 1'b1;
        srcLog.delete();
        tagLog.delete();
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got no finish, expected end of test");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        checks   = 0;
        errors   = 0;
        gapPct   = 0;
        reset_ni = 1'b1;
        for (int s = 0; s < 3; s++) begin
            vld[s]    = 1'b0;
            tagIn[s]  = '0;
            dataIn[s] = '0;
        end
        clearModel();
        #2 reset_ni = 1'b0;

        repeat (3) @(negedge clk_i);
        checkOutput("rst_en", {63'd0, cdb_en_o}, 64'd0);
        checkOutput("rst_tag", 64'(cdb_tag_o), 64'd0);
        checkOutput("rst_data", 64'(cdb_data_o), 64'd0);
        checkOutput("rst_src", 64'(cdb_src_o), 64'd0);
        for (int s = 0; s < 3; s++) checkOutput($sformatf("rst_ready%0d", s), {63'd0, rdy[s]}, 64'd1);
        reset_ni = 1'b1;

        $display("[TB] single completion");
        srcQ[0].push_back(mkItem(5'd7, 32'hDEADBEEF));
        stepCycle();
        stepCycle();
        @(negedge clk_i);
        checkOutput("single_en_early", {63'd0, cdb_en_o}, 64'd0);
        stepCycle();
        @(negedge clk_i);
        checkOutput("single_en", {63'd0, cdb_en_o}, 64'd1);
        checkOutput("single_tag", 64'(cdb_tag_o), 64'd7);
        checkOutput("single_data", 64'(cdb_data_o), 64'hDEADBEEF);
        checkOutput("single_src", 64'(cdb_src_o), 64'd0);
        stepCycle();
        @(negedge clk_i);
        checkOutput("single_en_drop", {63'd0, cdb_en_o}, 64'd0);

        $display("[TB] three-way contention");
        doReset();
        srcQ[0].push_back(mkItem(5'd1, 32'h11111111));
        srcQ[1].push_back(mkItem(5'd2, 32'h22222222));
        srcQ[2].push_back(mkItem(5'd3, 32'h33333333));
        applyStimulus(0);
        checkOutput("contend_count", 64'(srcLog.size()), 64'd3);
        for (int i = 0; i < 3 && i < srcLog.size(); i++) begin
            checkOutput($sformatf("contend_src%0d", i), 64'(srcLog[i]), 64'(i));
            checkOutput($sformatf("contend_tag%0d", i), 64'(tagLog[i]), 64'(i + 1));
        end

        $display("[TB] round-robin fairness");
        doReset();
        for (int i = 0; i < 20; i++) begin
            srcQ[0].push_back(mkItem(5'(i), $urandom));
            srcQ[1].push_back(mkItem(5'(i + 8), $urandom));
        end
        applyStimulus(0);
        checkOutput("fair_count", 64'(srcLog.size()), 64'd40);
        for (int i = 0; i < srcLog.size(); i++) begin
            checkOutput($sformatf("fair_src%0d", i), 64'(srcLog[i]), 64'(i % 2));
        end

        $display("[TB] full and backpressure");
        doReset();
        for (int i = 0; i < 6; i++) begin
            srcQ[0].push_back(mkItem(5'(10 + i), $urandom));
            srcQ[1].push_back(mkItem(5'(20 + i), $urandom));
        end
        srcQ[2].push_back(mkItem(5'd4, 32'h44444444));
        srcQ[2].push_back(mkItem(5'd5, 32'h55555555));
        srcQ[2].push_back(mkItem(5'd6, 32'h66666666));
        stepCycle();
        stepCycle();
        stepCycle();
        @(negedge clk_i);
        checkOutput("lsu_full_ready", {63'd0, rdy[2]}, 64'd0);
        applyStimulus(0);
        n = 0;
        for (int i = 0; i < srcLog.size(); i++) begin
            if (srcLog[i] == 2) begin
                checkOutput($sformatf("lsu_order%0d", n), 64'(tagLog[i]), 64'(4 + n));
                n++;
            end
        end
        checkOutput("lsu_bcast_count", 64'(n), 64'd3);

        $display("[TB] reset mid-operation");
        doReset();
        for (int i = 0; i < 3; i++) begin
            srcQ[0].push_back(mkItem(5'(i), $urandom));
            srcQ[1].push_back(mkItem(5'(i + 16), $urandom));
        end
        stepCycle();
        stepCycle();
        stepCycle();
        #3;
        reset_ni = 1'b0;
        clearModel();
        #1;
        checkOutput("async_rst_en", {63'd0, cdb_en_o}, 64'd0);
        for (int s = 0; s < 3; s++) checkOutput($sformatf("async_rst_ready%0d", s), {63'd0, rdy[s]}, 64'd1);
        for (int s = 0; s < 3; s++) begin
            srcQ[s].delete();
            vld[s] = 1'b0;
        end
        repeat (2) @(negedge clk_i);
        reset_ni = 1'b1;

        $display("[TB] wrap-around stress");
        for (int s = 0; s < 3; s++) begin
            for (int i = 0; i < 50; i++) srcQ[s].push_back(mkItem(5'($urandom), $urandom));
        end
        applyStimulus(40);
        checkOutput("sb_drained", 64'(sbq.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
